// File: rtl/repetition_pkg.sv
// Shared types and widths for the repetition generator.
// Optional inter-burst gap is selected in the top module by REPETITION_GEN_GAP_EN.
package repetition_pkg;

  localparam int unsigned DEFAULT_LEN_W = 8;
  localparam int unsigned COUNT_W       = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StGap  = 2'd2
  } rep_state_e;

endpackage

// File: rtl/repetition_gen.sv
// Emits a registered high burst of req_len cycles per accepted request and counts completions.
// Define REPETITION_GEN_GAP_EN to force GAP low cycles after every burst instead of chaining.
module repetition_gen
  import repetition_pkg::*;
#(
  parameter int unsigned LEN_W = DEFAULT_LEN_W,
  parameter int unsigned GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 req_ready,
  output logic                 a,
  output logic                 busy,
  output logic                 done,
  output logic [COUNT_W-1:0]   burst_count
);

  if (GAP < 1 || GAP > 15) begin : g_gap_range
    $error("repetition_gen: GAP must be in 1..15");
  end

  rep_state_e         state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               a_q, a_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [1:0]         n_done;
  logic [COUNT_W:0]   count_sum;
  logic               accept;

  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      StIdle:  req_ready = 1'b1;
`ifdef REPETITION_GEN_GAP_EN
      StRun:   req_ready = 1'b0;
`else
      StRun:   req_ready = (cnt_q == LEN_W'(1));
`endif
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = 1'b0;
    n_done  = 2'd0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_len != '0) begin
            state_d = StRun;
            cnt_d   = req_len;
            a_d     = 1'b1;
          end else begin
            n_done = 2'd1;
          end
        end
      end
      StRun: begin
        if (cnt_q == LEN_W'(1)) begin
          n_done = 2'd1;
`ifdef REPETITION_GEN_GAP_EN
          state_d = StGap;
          cnt_d   = LEN_W'(GAP);
`else
          if (accept && req_len != '0) begin
            cnt_d = req_len;
            a_d   = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
            // A chained zero-length request completes in the same cycle as the burst.
            if (accept) n_done = 2'd2;
          end
`endif
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          a_d   = 1'b1;
        end
      end
      StGap: begin
        if (cnt_q <= LEN_W'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    done_d    = (n_done != 2'd0);
    count_sum = {1'b0, count_q} + {{(COUNT_W-1){1'b0}}, n_done};
    count_d   = count_sum[COUNT_W] ? {COUNT_W{1'b1}} : count_sum[COUNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign a           = a_q;
  assign done        = done_q;
  assign busy        = (state_q != StIdle);
  assign burst_count = count_q;

endmodule
